// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the registered multi-lane half adder.
package half_adder_pkg;

    localparam int HA_LANES_MAX = 64;

    // Width needed to hold a population count of 0..lanes.
    function automatic int ha_count_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational 1-bit half-adder cell: sum = a ^ b, carry = a & b.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered multi-lane half adder behind a single-entry valid/ready output stage.
// Optional carry popcount output enabled by defining HALF_ADDER_CARRY_COUNT_EN.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] sum,
    output logic [LANES-1:0] carry,
`ifdef HALF_ADDER_CARRY_COUNT_EN
    output logic [ha_count_w(LANES)-1:0] carry_count,
`endif
    output logic             carry_any
);

    logic [LANES-1:0] sum_next;
    logic [LANES-1:0] carry_next;
    logic             carry_any_next;
    logic [LANES-1:0] sum_reg;
    logic [LANES-1:0] carry_reg;
    logic             carry_any_reg;
    logic             out_valid_reg;
    logic             accept;
    logic             fire;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            half_adder_cell u_cell (
                .a     (a[gi]),
                .b     (b[gi]),
                .sum   (sum_next[gi]),
                .carry (carry_next[gi])
            );
        end
    endgenerate

    assign carry_any_next = |carry_next;

    // Single-entry stage: a slot frees up in the same cycle the result leaves.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            carry_reg     <= '0;
            carry_any_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            sum_reg       <= sum_next;
            carry_reg     <= carry_next;
            carry_any_reg <= carry_any_next;
        end else if (fire) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef HALF_ADDER_CARRY_COUNT_EN
    localparam int CW = ha_count_w(LANES);

    logic [CW-1:0] count_next;
    logic [CW-1:0] count_reg;

    always_comb begin
        count_next = '0;
        for (int i = 0; i < LANES; i++) begin
            count_next = count_next + CW'(carry_next[i]);
        end
    end

    // Follows the same load/hold rules as carry_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_next;
        end
    end

    assign carry_count = count_reg;
`endif

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry     = carry_reg;
    assign carry_any = carry_any_reg;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a 1-lane and a 4-lane instance share
// handshakes; a queue scoreboard checks every result that leaves the stage.
module tb_half_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       in_ready1, in_ready4;
    logic       out_valid1, out_valid4;
    logic       sum1, carry1, any1;
    logic [3:0] sum4, carry4;
    logic       any4;
`ifdef HALF_ADDER_CARRY_COUNT_EN
    logic [0:0] cnt1;
    logic [2:0] cnt4;
`endif

    typedef struct packed {
        logic       s1;
        logic       c1;
        logic       y1;
        logic [3:0] s4;
        logic [3:0] c4;
        logic       y4;
        logic [0:0] n1;
        logic [2:0] n4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fires  = 0;

    half_adder #(.LANES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .sum       (sum1),
        .carry     (carry1),
`ifdef HALF_ADDER_CARRY_COUNT_EN
        .carry_count (cnt1),
`endif
        .carry_any (any1)
    );

    half_adder #(.LANES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .sum       (sum4),
        .carry     (carry4),
`ifdef HALF_ADDER_CARRY_COUNT_EN
        .carry_count (cnt4),
`endif
        .carry_any (any4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic xa1, input logic xb1,
                                   input logic [3:0] xa4, input logic [3:0] xb4);
        exp_t e;
        e.s1 = xa1 ^ xb1;
        e.c1 = xa1 & xb1;
        e.y1 = e.c1;
        e.n1 = e.c1;
        e.s4 = xa4 ^ xb4;
        e.c4 = xa4 & xb4;
        e.y4 = (e.c4 != 4'b0000);
        e.n4 = 3'(e.c4[0]) + 3'(e.c4[1]) + 3'(e.c4[2]) + 3'(e.c4[3]);
        return e;
    endfunction

    // Scoreboard: pop on output fire, then push on input accept (same edge order).
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got sum1=%b sum4=%b expected no result", sum1, sum4);
                end else begin
                    e = sb.pop_front();
                    fires++;
                    if ({sum1, carry1, any1, sum4, carry4, any4} !==
                        {e.s1, e.c1, e.y1, e.s4, e.c4, e.y4}) begin
                        errors++;
                        $display("FAIL result got s1=%b c1=%b y1=%b s4=%b c4=%b y4=%b expected s1=%b c1=%b y1=%b s4=%b c4=%b y4=%b",
                                 sum1, carry1, any1, sum4, carry4, any4,
                                 e.s1, e.c1, e.y1, e.s4, e.c4, e.y4);
                    end
`ifdef HALF_ADDER_CARRY_COUNT_EN
                    checks++;
                    if ({cnt1, cnt4} !== {e.n1, e.n4}) begin
                        errors++;
                        $display("FAIL carry_count got n1=%0d n4=%0d expected n1=%0d n4=%0d",
                                 cnt1, cnt4, e.n1, e.n4);
                    end
`endif
                end
            end
            if (in_valid && in_ready1) sb.push_back(model(a1, b1, a4, b4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({out_valid1, out_valid4, sum1, carry1, any1, sum4, carry4, any4} !== 12'b0) begin
                errors++;
                $display("FAIL reset_state got ov1=%b ov4=%b s1=%b c1=%b s4=%b c4=%b expected all 0",
                         out_valid1, out_valid4, sum1, carry1, sum4, carry4);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready1, in_ready4} !== 2'b11) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b expected 11", in_ready1, in_ready4);
        end
        $display("reset: released, out_valid=%b in_ready=%b", out_valid1, in_ready1);
        cyc();
    endtask

    task automatic test_directed();
        out_ready = 1'b1; in_valid = 1'b1;
        a1 = 1'b0; b1 = 1'b1; a4 = 4'b0011; b4 = 4'b0101;
        cyc();
        checks++;
        if ({out_valid1, sum1, carry1} !== 3'b110) begin
            errors++;
            $display("FAIL directed_01 got ov=%b s=%b c=%b expected ov=1 s=1 c=0", out_valid1, sum1, carry1);
        end
        $display("directed: a=0 b=1 -> sum=%b carry=%b", sum1, carry1);
        a1 = 1'b1; b1 = 1'b1;
        cyc();
        checks++;
        if ({out_valid1, sum1, carry1, any1} !== 4'b1011) begin
            errors++;
            $display("FAIL directed_11 got ov=%b s=%b c=%b any=%b expected ov=1 s=0 c=1 any=1",
                     out_valid1, sum1, carry1, any1);
        end
        $display("directed: a=1 b=1 -> sum=%b carry=%b carry_any=%b", sum1, carry1, any1);
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ab;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            cyc();
            checks++;
            if ({out_valid1, sum1, carry1} !== {1'b1, ab[1] ^ ab[0], ab[1] & ab[0]}) begin
                errors++;
                $display("FAIL b2b_%0d got ov=%b s=%b c=%b expected ov=1 s=%b c=%b",
                         i, out_valid1, sum1, carry1, ab[1] ^ ab[0], ab[1] & ab[0]);
            end
            $display("b2b: a=%b b=%b -> sum=%b carry=%b", ab[1], ab[0], sum1, carry1);
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got ov=%b expected 0", out_valid1);
        end
    endtask

    task automatic test_lanes4();
        out_ready = 1'b1; in_valid = 1'b1;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'b1100; b4 = 4'b1010;
        cyc();
        checks++;
        if ({sum4, carry4, any4} !== {4'b0110, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL lanes4 got s=%b c=%b any=%b expected s=0110 c=1000 any=1", sum4, carry4, any4);
        end
`ifdef HALF_ADDER_CARRY_COUNT_EN
        checks++;
        if (cnt4 !== 3'd1) begin
            errors++;
            $display("FAIL lanes4_count got %0d expected 1", cnt4);
        end
`endif
        $display("lanes4: a=1100 b=1010 -> sum=%b carry=%b carry_any=%b", sum4, carry4, any4);
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a4 = 4'b0111; b4 = 4'b0011;
        cyc();
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = ~b1; a4 = ~a4; b4 = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if ({in_ready1, in_ready4} !== 2'b00) begin
                errors++;
                $display("FAIL bp_in_ready_%0d got %b%b expected 00", i, in_ready1, in_ready4);
            end
            cyc();
            checks++;
            if ({out_valid4, sum4, carry4, sum1, carry1} !== {1'b1, 4'b0100, 4'b0011, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d got ov=%b s4=%b c4=%b s1=%b c1=%b expected ov=1 s4=0100 c4=0011 s1=1 c1=0",
                         i, out_valid4, sum4, carry4, sum1, carry1);
            end
            $display("backpressure %0d: held sum4=%b carry4=%b", i, sum4, carry4);
        end
        out_ready = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'b1111; b4 = 4'b0001;
        #1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b expected 1", in_ready4);
        end
        cyc();
        checks++;
        if ({out_valid4, sum4, carry4} !== {1'b1, 4'b1110, 4'b0001}) begin
            errors++;
            $display("FAIL bp_replace got ov=%b s4=%b c4=%b expected ov=1 s4=1110 c4=0001",
                     out_valid4, sum4, carry4);
        end
        $display("backpressure release: fire+load sum4=%b carry4=%b", sum4, carry4);
        in_valid = 1'b0; a1 = 1'bx; b1 = 1'bx; a4 = 4'bxxxx; b4 = 4'bxxxx;
        cyc();
        cyc();
        checks++;
        if ({out_valid4, sum4, carry4, sum1, carry1} !== {1'b0, 4'b1110, 4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL idle_x_hold got ov=%b s4=%b c4=%b s1=%b c1=%b expected ov=0 s4=1110 c4=0001 s1=0 c1=1",
                     out_valid4, sum4, carry4, sum1, carry1);
        end
        $display("idle with X operands: sum4=%b carry4=%b", sum4, carry4);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        checks++;
        if ({out_valid1, out_valid4, sum1, carry1, any1, sum4, carry4, any4} !== 12'b0) begin
            errors++;
            $display("FAIL mid_reset got ov=%b s4=%b c4=%b any4=%b expected all 0",
                     out_valid4, sum4, carry4, any4);
        end
`ifdef HALF_ADDER_CARRY_COUNT_EN
        checks++;
        if (cnt4 !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_count got %0d expected 0", cnt4);
        end
`endif
        rst = 1'b0; out_ready = 1'b1;
        cyc();
        checks++;
        if (out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after got ov=%b expected 0", out_valid4);
        end
        $display("reset mid-operation: out_valid=%b sum4=%b", out_valid4, sum4);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_lanes4();
        test_backpressure();
        test_reset_mid();
        cyc();
        checks++;
        if (fires != 9 || sb.size() != 0) begin
            errors++;
            $display("FAIL result_count got fired=%0d pending=%0d expected fired=9 pending=0", fires, sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
